// File: rtl/router_pkg.sv
// Shared constants, header field layout and reader state encoding for the
// 1x3 router destination-side logic.
package router_pkg;
    localparam int ROUTER_DATA_W = 8;
    localparam int ROUTER_LEN_W  = 6;

    // Header layout: {len[7:2], addr[1:0]}
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_W   = 2;
    localparam int HDR_LEN_LSB  = 2;

    localparam logic [HDR_ADDR_W-1:0] PORT0_ADDR = 2'b00;
    localparam logic [HDR_ADDR_W-1:0] PORT1_ADDR = 2'b01;
    localparam logic [HDR_ADDR_W-1:0] PORT2_ADDR = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HDR_WAIT = 2'd1,
        BODY     = 2'd2
    } rd_state_t;
endpackage

// File: rtl/router_skid_buf2.sv
// Two-entry output buffer between the FIFO reader and the ready/valid sink.
// Exposes its occupancy so the reader can budget FIFO reads against it.
module router_skid_buf2 #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic [1:0]   occ
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    // Storage: pointers are reset/flushed, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping; flush empties the buffer outright.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign valid = (occ != 2'd0);
    assign head  = valid ? mem[rd_ptr] : '0;
endmodule

// File: rtl/router_pkt_reader.sv
// Destination-side packet reader for one router output port.
// Pops the port FIFO whenever downstream space allows, forwards header and
// payload bytes with sop/eop marks, and checks parity and destination address.
// Optional statistics counters: define ROUTER_PKT_READER_STATS_EN.
module router_pkt_reader
    import router_pkg::*;
#(
    parameter int              DATA_W    = ROUTER_DATA_W,
    parameter int              LEN_W     = ROUTER_LEN_W,
    parameter logic [1:0]      PORT_ADDR = PORT0_ADDR
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              vld_out,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              soft_reset,
    output logic              read_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic              pkt_done,
    output logic              parity_err,
    output logic              addr_err,
    output logic              pkt_abort
`ifdef ROUTER_PKT_READER_STATS_EN
    ,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       perr_cnt,
    output logic [15:0]       abort_cnt
`endif
);
    rd_state_t         state;
    logic [LEN_W-1:0]  rem_rd;     // payload reads still to issue
    logic              par_rd;     // parity read already issued
    logic              infl;       // a read is returning data this cycle
    logic              infl_par;   // ...and it is the parity byte
    logic              infl_last;  // ...and it is the last payload byte
    logic [DATA_W-1:0] chk;        // running XOR of header and payload
    logic              addr_mis;
    logic [1:0]        occ;
    logic              credit;
    logic              cap, hdr_cap, pay_cap, par_cap;
    logic              buf_push, buf_pop, push_eop;
    logic [LEN_W-1:0]  hdr_len;
    logic [DATA_W+1:0] head;

    assign hdr_len = fifo_dout[HDR_LEN_LSB +: LEN_W];
    // Every forwarded byte must already have a buffer slot when it is read.
    assign credit  = ({1'b0, occ} + {2'b0, infl}) < 3'd2;
    // soft_reset discards whatever the FIFO returns in the same cycle.
    assign cap     = infl && !soft_reset;
    assign hdr_cap = cap && (state == HDR_WAIT);
    assign pay_cap = cap && (state == BODY) && !infl_par;
    assign par_cap = cap && (state == BODY) && infl_par;

    // Read issue: headers and payload need a buffer credit, parity does not.
    always_comb begin
        read_en = 1'b0;
        if (resetn && !soft_reset && vld_out) begin
            case (state)
                IDLE:    read_en = credit;
                BODY:    if (!par_rd) read_en = (rem_rd != '0) ? credit : 1'b1;
                default: read_en = 1'b0;
            endcase
        end
    end

    // Status pulses are flagged in the capture cycle itself so the FSM is
    // back in IDLE, and can read the next header, on the very next cycle.
    assign pkt_done   = par_cap;
    assign parity_err = par_cap && ((chk ^ fifo_dout) != '0);
    assign addr_err   = par_cap && addr_mis;
    assign pkt_abort  = resetn && soft_reset && (state != IDLE);

    assign buf_push = hdr_cap || pay_cap;
    assign push_eop = hdr_cap ? (hdr_len == '0) : infl_last;
    assign buf_pop  = out_valid && out_ready;

    router_skid_buf2 #(.W(DATA_W + 2)) u_buf (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (soft_reset),
        .push      (buf_push),
        .push_data ({fifo_dout, hdr_cap, push_eop}),
        .pop       (buf_pop),
        .head      (head),
        .valid     (out_valid),
        .occ       (occ)
    );

    assign out_data = head[DATA_W+1:2];
    assign out_sop  = head[1];
    assign out_eop  = head[0];

    // Packet parser FSM: header, payload countdown, single parity read.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            rem_rd    <= '0;
            par_rd    <= 1'b0;
            infl      <= 1'b0;
            infl_par  <= 1'b0;
            infl_last <= 1'b0;
            chk       <= '0;
            addr_mis  <= 1'b0;
        end else if (soft_reset) begin
            state  <= IDLE;
            rem_rd <= '0;
            par_rd <= 1'b0;
            infl   <= 1'b0;
        end else begin
            infl <= read_en;
            if (read_en) begin
                infl_par  <= (state == BODY) && (rem_rd == '0);
                infl_last <= (state == BODY) && (rem_rd == LEN_W'(1));
            end
            case (state)
                IDLE: if (read_en) state <= HDR_WAIT;
                HDR_WAIT: if (hdr_cap) begin
                    state    <= BODY;
                    rem_rd   <= hdr_len;
                    par_rd   <= 1'b0;
                    chk      <= fifo_dout;
                    addr_mis <= (fifo_dout[HDR_ADDR_LSB +: HDR_ADDR_W] != PORT_ADDR);
                end
                BODY: begin
                    if (read_en) begin
                        if (rem_rd != '0) rem_rd <= rem_rd - 1'b1;
                        else              par_rd <= 1'b1;
                    end
                    if (pay_cap) chk <= chk ^ fifo_dout;
                    if (par_cap) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ROUTER_PKT_READER_STATS_EN
    // Saturating event counters, cleared only by resetn.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pkt_cnt   <= '0;
            perr_cnt  <= '0;
            abort_cnt <= '0;
        end else begin
            if (pkt_done && pkt_cnt != 16'hFFFF)                 pkt_cnt   <= pkt_cnt + 16'd1;
            if (pkt_done && parity_err && perr_cnt != 16'hFFFF)  perr_cnt  <= perr_cnt + 16'd1;
            if (pkt_abort && abort_cnt != 16'hFFFF)              abort_cnt <= abort_cnt + 16'd1;
        end
    end
`endif
endmodule
